// File: rtl/word_aligner_if.sv
// Raw deserializer stream into the word aligner and the aligned word stream out of it.
interface word_aligner_if;
  logic [19:0] raw_data_i;
  logic        raw_vld_i;
  logic [19:0] data_out_o;
  logic        data_vld_o;

  // Handshake: raw_vld_i qualifies raw_data_i for exactly one cycle and there is
  // no backpressure; data_vld_o qualifies data_out_o for one cycle and the sink
  // (elastic buffer write side) must take it in that cycle.
  modport master (
    output raw_data_i,
    output raw_vld_i,
    input  data_out_o,
    input  data_vld_o
  );

  modport slave (
    input  raw_data_i,
    input  raw_vld_i,
    output data_out_o,
    output data_vld_o
  );
endinterface

// File: rtl/word_aligner.sv
// Comma-based 10-bit symbol aligner for a 20-bit deserializer stream (HUNT/VERIFY/LOCKED).
// Optional macro WA_LOSS_TIMEOUT_EN drops lock after 1023 words without an aligned comma.
module word_aligner #(
  parameter logic [9:0] COMMA_POS = 10'h17C,
  parameter logic [9:0] COMMA_NEG = 10'h283
) (
  input  logic                cdr_clk_i,
  input  logic                sys_arst_n_i,
  word_aligner_if.slave       bus,
  input  logic [3:0]          cfg_lock_cnt_i,
  input  logic [3:0]          cfg_unlock_cnt_i,
  output logic                lock_o,
  output logic [3:0]          align_offset_o,
  output logic [7:0]          relock_cnt_o,
  output logic [1:0]          dbg_state_o,
  output logic [3:0]          dbg_match_cnt_o,
  output logic [3:0]          dbg_miss_cnt_o
);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  off_q, off_d;
  logic [3:0]  match_q, match_d;
  logic [3:0]  miss_q, miss_d;
  logic [7:0]  relock_q, relock_d;
  logic [19:0] raw_q;
  logic [19:0] dout_q;
  logic        dvld_q;
  logic        lock_q;
  logic        drop;

  // Only window bits 0..28 can ever be inspected (20 comma start positions,
  // 20-bit output slice at offsets 0..9), so the upper raw bits are left out.
  logic [28:0] win;
  assign win = {bus.raw_data_i[8:0], raw_q};

  logic [19:0] comma_hit;
  for (genvar p = 0; p < 20; p++) begin : g_hit
    assign comma_hit[p] = (win[p+9:p] == COMMA_POS) || (win[p+9:p] == COMMA_NEG);
  end

  logic comma_any;
  assign comma_any = |comma_hit;

  // Lowest matching start position wins; its phase within a symbol is the offset.
  logic [3:0] cand_off;
  always_comb begin
    cand_off = 4'd0;
    for (int p = 19; p >= 0; p--) begin
      if (comma_hit[p]) cand_off = 4'(p % 10);
    end
  end

  logic [4:0] idx_lo, idx_hi;
  logic       aligned;
  assign idx_lo  = {1'b0, off_q};
  assign idx_hi  = idx_lo + 5'd10;
  assign aligned = comma_hit[idx_lo] | comma_hit[idx_hi];

  logic [19:0] aligned_word;
  always_comb begin
    aligned_word = win[19:0];
    case (off_q)
      4'd0:    aligned_word = win[19:0];
      4'd1:    aligned_word = win[20:1];
      4'd2:    aligned_word = win[21:2];
      4'd3:    aligned_word = win[22:3];
      4'd4:    aligned_word = win[23:4];
      4'd5:    aligned_word = win[24:5];
      4'd6:    aligned_word = win[25:6];
      4'd7:    aligned_word = win[26:7];
      4'd8:    aligned_word = win[27:8];
      4'd9:    aligned_word = win[28:9];
      default: aligned_word = win[19:0];
    endcase
  end

  logic [3:0] lock_need, unlock_need;
  assign lock_need   = (cfg_lock_cnt_i   == 4'd0) ? 4'd1 : cfg_lock_cnt_i;
  assign unlock_need = (cfg_unlock_cnt_i == 4'd0) ? 4'd1 : cfg_unlock_cnt_i;

  logic [4:0] match_inc, miss_inc;
  assign match_inc = {1'b0, match_q} + 5'd1;
  assign miss_inc  = {1'b0, miss_q} + 5'd1;

`ifdef WA_LOSS_TIMEOUT_EN
  localparam logic [9:0] TIMEOUT_LAST = 10'd1022;
  logic [9:0] to_q;
`endif

  always_comb begin
    state_d  = state_q;
    off_d    = off_q;
    match_d  = match_q;
    miss_d   = miss_q;
    relock_d = relock_q;
    drop     = 1'b0;
    if (bus.raw_vld_i) begin
      case (state_q)
        ST_HUNT: begin
          if (comma_any) begin
            off_d   = cand_off;
            match_d = 4'd1;
            state_d = (lock_need == 4'd1) ? ST_LOCKED : ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (aligned) begin
            match_d = match_inc[3:0];
            if (match_inc >= {1'b0, lock_need}) state_d = ST_LOCKED;
          end else if (comma_any) begin
            off_d   = cand_off;
            match_d = 4'd1;
          end
        end
        ST_LOCKED: begin
          if (aligned) begin
            miss_d = 4'd0;
          end else if (comma_any) begin
            miss_d = miss_inc[3:0];
            if (miss_inc >= {1'b0, unlock_need}) drop = 1'b1;
          end
`ifdef WA_LOSS_TIMEOUT_EN
          if (!aligned && (to_q == TIMEOUT_LAST)) drop = 1'b1;
`endif
          if (drop) begin
            state_d = ST_HUNT;
            match_d = 4'd0;
            miss_d  = 4'd0;
            if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge cdr_clk_i or negedge sys_arst_n_i) begin
    if (!sys_arst_n_i) begin
      state_q  <= ST_HUNT;
      off_q    <= 4'd0;
      match_q  <= 4'd0;
      miss_q   <= 4'd0;
      relock_q <= 8'd0;
      raw_q    <= 20'd0;
      dout_q   <= 20'd0;
      dvld_q   <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      off_q    <= off_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      relock_q <= relock_d;
      lock_q   <= (state_d == ST_LOCKED);
      // Output qualification uses the state before this word's update, so the
      // word that completes the lock is never presented downstream.
      dvld_q   <= bus.raw_vld_i && (state_q == ST_LOCKED);
      if (bus.raw_vld_i) raw_q <= bus.raw_data_i;
      if (bus.raw_vld_i && (state_q == ST_LOCKED)) dout_q <= aligned_word;
    end
  end

`ifdef WA_LOSS_TIMEOUT_EN
  always_ff @(posedge cdr_clk_i or negedge sys_arst_n_i) begin
    if (!sys_arst_n_i) begin
      to_q <= 10'd0;
    end else if (bus.raw_vld_i) begin
      if ((state_q != ST_LOCKED) || aligned || drop) to_q <= 10'd0;
      else                                           to_q <= to_q + 10'd1;
    end
  end
`endif

  assign bus.data_out_o  = dout_q;
  assign bus.data_vld_o  = dvld_q;
  assign lock_o          = lock_q;
  assign align_offset_o  = off_q;
  assign relock_cnt_o    = relock_q;
  assign dbg_state_o     = state_q;
  assign dbg_match_cnt_o = match_q;
  assign dbg_miss_cnt_o  = miss_q;

endmodule

// File: tb/tb_word_aligner.sv
// Bench for word_aligner: bit-level symbol stream generator, behavioural alignment model, directed and random steps.
module tb_word_aligner;

  localparam logic [9:0] K_POS = 10'h17C;
  localparam logic [9:0] K_NEG = 10'h283;
  localparam int PH_HUNT   = 0;
  localparam int PH_VERIFY = 1;
  localparam int PH_LOCKED = 2;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] cfg_lock, cfg_unlock;
  logic       lock;
  logic [3:0] off;
  logic [7:0] relock;
  logic [1:0] dbg_state;
  logic [3:0] dbg_match, dbg_miss;

  word_aligner_if bus ();

  word_aligner dut (
    .cdr_clk_i        (clk),
    .sys_arst_n_i     (rst_n),
    .bus              (bus),
    .cfg_lock_cnt_i   (cfg_lock),
    .cfg_unlock_cnt_i (cfg_unlock),
    .lock_o           (lock),
    .align_offset_o   (off),
    .relock_cnt_o     (relock),
    .dbg_state_o      (dbg_state),
    .dbg_match_cnt_o  (dbg_match),
    .dbg_miss_cnt_o   (dbg_miss)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // serial bit stream, earliest bit at the front
  bit bq[$];

  // behavioural reference
  int          m_phase, m_off, m_match, m_miss, m_relock, m_to;
  logic [19:0] m_prev, m_dout;
  bit          m_dvld;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = PH_HUNT; m_off = 0; m_match = 0; m_miss = 0;
    m_relock = 0; m_to = 0; m_prev = '0; m_dout = '0; m_dvld = 0;
  endtask

  task automatic go_locked();
    m_phase = PH_LOCKED; m_miss = 0; m_to = 0;
  endtask

  task automatic model_step(input logic vld, input logic [19:0] d);
    logic [39:0] w;
    logic [9:0]  s;
    int cand, need_l, need_u;
    bit aligned, drop;
    m_dvld = 0;
    if (!vld) return;
    w = {d, m_prev};
    m_prev = d;
    if (m_phase == PH_LOCKED) begin
      m_dvld = 1;
      m_dout = 20'(w >> m_off);
    end
    cand = -1; aligned = 0;
    for (int p = 0; p < 20; p++) begin
      s = 10'(w >> p);
      if (s == K_POS || s == K_NEG) begin
        if (cand < 0) cand = p % 10;
        if (p % 10 == m_off) aligned = 1;
      end
    end
    need_l = (cfg_lock == 0) ? 1 : int'(cfg_lock);
    need_u = (cfg_unlock == 0) ? 1 : int'(cfg_unlock);
    case (m_phase)
      PH_HUNT: if (cand >= 0) begin
        m_off = cand; m_match = 1;
        if (need_l == 1) go_locked(); else m_phase = PH_VERIFY;
      end
      PH_VERIFY: begin
        if (aligned) begin
          m_match++;
          if (m_match >= need_l) go_locked();
        end else if (cand >= 0) begin
          m_off = cand; m_match = 1;
        end
      end
      default: begin
        drop = 0;
        if (aligned) m_miss = 0;
        else if (cand >= 0) begin
          m_miss++;
          if (m_miss >= need_u) drop = 1;
        end
`ifdef WA_LOSS_TIMEOUT_EN
        if (aligned) m_to = 0;
        else begin
          m_to++;
          if (m_to >= 1023) drop = 1;
        end
`endif
        if (drop) begin
          m_phase = PH_HUNT; m_match = 0; m_miss = 0; m_to = 0;
          if (m_relock < 255) m_relock++;
        end
      end
    endcase
  endtask

  function automatic logic [1:0] exp_state();
    if (m_phase == PH_LOCKED) return 2'd2;
    if (m_phase == PH_VERIFY) return 2'd1;
    return 2'd0;
  endfunction

  task automatic check_all();
    chk("lock",     lock,           (m_phase == PH_LOCKED));
    chk("offset",   off,            m_off);
    chk("relock",   relock,         m_relock);
    chk("data_vld", bus.data_vld_o, m_dvld);
    chk("data_out", bus.data_out_o, m_dout);
    chk("state",    dbg_state,      exp_state());
    chk("match",    dbg_match,      m_match);
    chk("miss",     dbg_miss,       m_miss);
  endtask

  // stream builders: filler symbols and slip bits never contain five equal bits in a row
  function automatic logic [9:0] fill_sym();
    case ($urandom_range(0, 3))
      0:       return 10'h155;
      1:       return 10'h2AA;
      2:       return 10'h133;
      default: return 10'h0CC;
    endcase
  endfunction

  task automatic push_sym(input logic [9:0] s);
    for (int i = 0; i < 10; i++) bq.push_back(s[i]);
  endtask

  task automatic push_fill_bits(input int n);
    for (int i = 0; i < n; i++) bq.push_back((i % 2) == 0);
  endtask

  // driver
  task automatic drive_cycle(input logic vld, input logic [19:0] w);
    bus.raw_vld_i  = vld;
    bus.raw_data_i = w;
    @(posedge clk);
    model_step(vld, w);
    #1;
    check_all();
  endtask

  task automatic send_word();
    logic [19:0] w;
    while (bq.size() < 20) push_sym(fill_sym());
    for (int i = 0; i < 20; i++) w[i] = bq.pop_front();
    drive_cycle(1'b1, w);
  endtask

  task automatic idle_cycle();
    drive_cycle(1'b0, 20'($urandom));
  endtask

  task automatic reset_pulse();
    bus.raw_vld_i = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_lock",   lock,           1'b0);
    chk("rst_off",    off,            4'd0);
    chk("rst_relock", relock,         8'd0);
    chk("rst_vld",    bus.data_vld_o, 1'b0);
    chk("rst_dout",   bus.data_out_o, 20'd0);
    chk("rst_state",  dbg_state,      2'd0);
    #10 rst_n = 1'b1;
  endtask

  initial begin
    bus.raw_vld_i  = 1'b0;
    bus.raw_data_i = '0;
    cfg_lock       = 4'd3;
    cfg_unlock     = 4'd2;
    model_reset();
    #12;
    chk("init_lock",   lock,           1'b0);
    chk("init_vld",    bus.data_vld_o, 1'b0);
    chk("init_off",    off,            4'd0);
    chk("init_relock", relock,         8'd0);
    chk("init_dout",   bus.data_out_o, 20'd0);
    rst_n = 1'b1;

    // lock on a comma stream at offset 3
    push_fill_bits(3);
    repeat (2) send_word();
    repeat (3) begin push_sym(K_POS); send_word(); end
    chk("no_lock_before_3rd", lock, 1'b0);
    send_word();
    chk("lock_after_3rd", lock, 1'b1);
    chk("lock_offset3", off, 4'd3);
    chk("lock_word_hidden", bus.data_vld_o, 1'b0);
    send_word();
    chk("first_valid", bus.data_vld_o, 1'b1);
    push_sym(K_POS); send_word(); send_word();
    chk("comma_on_output", bus.data_out_o[9:0], K_POS);

    // one misaligned comma, then a window with aligned and offset-8 commas
    push_fill_bits(5); push_sym(K_NEG); push_fill_bits(5);
    repeat (2) send_word();
    chk("miss_one", dbg_miss, 4'd1);
    push_sym(K_POS); push_fill_bits(5); push_sym(K_NEG); push_fill_bits(5);
    repeat (2) send_word();
    chk("both_is_aligned", dbg_miss, 4'd0);
    chk("both_still_locked", lock, 1'b1);

    // two commas at offset 7 -> back to hunt
    push_fill_bits(4);
    push_sym(K_POS); send_word();
    push_sym(K_POS); send_word();
    send_word();
    chk("unlock_lock", lock, 1'b0);
    chk("unlock_relock", relock, 8'd1);
    send_word();
    chk("unlock_vld", bus.data_vld_o, 1'b0);

    // relock at 7, then one miss followed by one aligned comma keeps lock
    repeat (3) begin push_sym(K_POS); send_word(); end
    send_word();
    chk("relock_at7", off, 4'd7);
    push_fill_bits(4); push_sym(K_POS); send_word();
    push_fill_bits(6); push_sym(K_POS); send_word();
    repeat (2) send_word();
    chk("miss_then_hit_lock", lock, 1'b1);
    chk("miss_then_hit_miss", dbg_miss, 4'd0);

    // asynchronous reset while locked, then full relock needed
    reset_pulse();
    repeat (2) begin push_sym(K_POS); send_word(); end
    send_word();
    chk("after_rst_verify", lock, 1'b0);
    // comma at offset 5 while verifying at 7
    push_fill_bits(8); push_sym(K_POS); send_word(); send_word();
    chk("relatch_off", off, 4'd5);
    chk("relatch_match", dbg_match, 4'd1);
    repeat (2) begin push_sym(K_POS); send_word(); end
    chk("lock_delayed", lock, 1'b0);
    send_word();
    chk("lock_at5", lock, 1'b1);

    // long comma-free run while locked
    repeat (2000) send_word();
`ifdef WA_LOSS_TIMEOUT_EN
    chk("timeout_lock", lock, 1'b0);
    chk("timeout_relock", relock, 8'd1);
`else
    chk("no_timeout_lock", lock, 1'b1);
    chk("no_timeout_relock", relock, 8'd0);
`endif

    // randomized stream against the model
    for (int k = 0; k < 600; k++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 30) begin
        push_sym(($urandom_range(0, 1) == 0) ? K_POS : K_NEG);
        send_word();
      end else if (r < 40) begin
        push_fill_bits($urandom_range(1, 9));
        send_word();
      end else if (r < 50) begin
        idle_cycle();
      end else if (r < 53) begin
        cfg_lock   = 4'($urandom_range(0, 4));
        cfg_unlock = 4'($urandom_range(0, 3));
        send_word();
      end else if (r < 54) begin
        reset_pulse();
      end else begin
        send_word();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/word_aligner.md
WORD_ALIGNER -- requirements
Module: word_aligner

Interface
REQ-001 SHALL have parameter COMMA_POS, default 10'h17C, meaning K28.5 RD- pattern as it appears in a 10-bit window slice.
REQ-002 SHALL have parameter COMMA_NEG, default 10'h283, meaning K28.5 RD+ pattern.
REQ-003 SHALL have port cdr_clk_i, input, 1 bit: recovered clock; all logic runs on its rising edge.
REQ-004 SHALL have port sys_arst_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port raw_data_i, input, 20 bits: unaligned deserializer word; bit 0 is the earliest received bit.
REQ-006 SHALL have port raw_vld_i, input, 1 bit: raw_data_i is valid this cycle.
REQ-007 SHALL have port cfg_lock_cnt_i, input, 4 bits: aligned commas required to lock; 0 is treated as 1.
REQ-008 SHALL have port cfg_unlock_cnt_i, input, 4 bits: consecutive misaligned commas that force relock; 0 is treated as 1.
REQ-009 SHALL have port data_out_o, output, 20 bits: aligned word that feeds the elastic buffer write side (data_in_i).
REQ-010 SHALL have port data_vld_o, output, 1 bit: aligned word valid; drives the elastic buffer wr_data_vld_i.
REQ-011 SHALL have port lock_o, output, 1 bit: high while the state is LOCKED.
REQ-012 SHALL have port align_offset_o, output, 4 bits: current bit offset, range 0..9.
REQ-013 SHALL have port relock_cnt_o, output, 8 bits: number of LOCKED->HUNT transitions, saturating at 255.

Function
REQ-014 SHALL register raw_q <= raw_data_i on each raw_vld_i; window = {raw_data_i, raw_q} (40 bits). Window is evaluated only when raw_vld_i = 1.
REQ-015 SHALL flag a comma at position p (0..19) when window[p+9:p] equals COMMA_POS or COMMA_NEG; the candidate offset is (lowest matching p) mod 10.
REQ-016 SHALL classify a comma as aligned when window[off+9:off] or window[off+19:off+10] matches, where off is the latched offset; aligned classification takes priority over any other match.
REQ-017 SHALL implement states HUNT, VERIFY, LOCKED, with HUNT after reset.
REQ-018 In HUNT, on any comma: SHALL latch off = candidate offset, set match_cnt = 1, and go to VERIFY, or directly to LOCKED if the effective lock count is 1.
REQ-019 In VERIFY: SHALL increment match_cnt on an aligned comma and go to LOCKED when match_cnt reaches the effective lock count. On a non-aligned comma it SHALL relatch off and set match_cnt = 1. Non-comma words SHALL leave the state unchanged.
REQ-020 In LOCKED: SHALL reset miss_cnt to 0 on an aligned comma, increment miss_cnt on a non-aligned comma, and go to HUNT when miss_cnt reaches the effective unlock count. Non-comma words SHALL leave miss_cnt unchanged.
REQ-021 On LOCKED->HUNT: SHALL clear match_cnt and miss_cnt and increment relock_cnt_o, saturating at 255.
REQ-022 SHALL register data_out_o <= window[off+19:off] and data_vld_o <= raw_vld_i && (state == LOCKED before the update), giving 1-cycle latency.
REQ-023 data_vld_o SHALL be 0 in HUNT and VERIFY; data_out_o SHALL hold its last value when data_vld_o = 0.
REQ-024 The word that completes the lock SHALL NOT be output; the first valid output is the next raw_vld_i word.
REQ-025 align_offset_o SHALL equal the latched off; lock_o SHALL be registered and equal (state == LOCKED).

Reset
REQ-026 Asserting sys_arst_n_i low at any time, including mid-lock, SHALL force: state HUNT; raw_q, data_out_o, off, match_cnt, miss_cnt, relock_cnt_o = 0; data_vld_o = 0; lock_o = 0.
REQ-027 After reset release, the first window SHALL use raw_q = 0.

Configuration
REQ-028 With WA_LOSS_TIMEOUT_EN defined: in LOCKED, a 10-bit counter SHALL count raw_vld_i words since the last aligned comma. When it reaches 1023, the block SHALL go to HUNT via the REQ-021 path. The counter SHALL clear on an aligned comma and on entry to LOCKED.
REQ-029 Without WA_LOSS_TIMEOUT_EN: the timeout counter SHALL be absent, and LOCKED SHALL exit only through REQ-020 or reset.

Verification
REQ-030 Comma stream at bit offset 3, cfg_lock_cnt_i = 3 -> lock_o rises after the 3rd comma word; align_offset_o = 3; data_vld_o = 1 one cycle after the next valid word; data_out_o[9:0] = 10'h17C on each comma word.
REQ-031 While LOCKED at offset 3, cfg_unlock_cnt_i = 2, inject 2 commas at offset 7 -> HUNT after the 2nd; relock_cnt_o = 1; data_vld_o = 0 on the next cycle. Repeat with 1 misaligned comma then 1 aligned comma -> stays LOCKED.
REQ-032 In VERIFY at offset 3, one comma at offset 5 -> off = 5, match_cnt = 1, lock delayed accordingly.
REQ-033 Window containing both offset 3 (aligned) and offset 8 commas -> treated as aligned; miss_cnt = 0.
REQ-034 sys_arst_n_i pulsed low while LOCKED -> all outputs 0 immediately; relock requires full cfg_lock_cnt_i.
REQ-035 With WA_LOSS_TIMEOUT_EN: LOCKED with 1023 comma-free valid words -> HUNT, relock_cnt_o increments. Without the macro: still LOCKED after 2000 words.
